// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM with programmable period, edge/centre counting and per-channel thresholds.
// Optional per-channel output polarity is compiled in with `define PWM_POLARITY_EN.
module pwm_multi_ctrl #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_i,
    input  logic                      center_i,
    input  logic [WIDTH-1:0]          period_i,
    input  logic [CHANNELS*WIDTH-1:0] thres_i,
    input  logic                      load_i,
`ifdef PWM_POLARITY_EN
    input  logic [CHANNELS-1:0]       polarity_i,
`endif
    output logic                      pending_o,
    output logic                      cycle_o,
    output logic [CHANNELS-1:0]       pwm_o
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Everything that travels through the shadow path as one unit.
    typedef struct packed {
        logic                           center;
        logic [WIDTH-1:0]               period;
        logic [CHANNELS-1:0][WIDTH-1:0] thr;
`ifdef PWM_POLARITY_EN
        logic [CHANNELS-1:0]            pol;
`endif
    } cfg_t;

    cfg_t                cfg_in;
    cfg_t                cfg_a;
    cfg_t                cfg_p;
    logic [WIDTH-1:0]    cnt;
    dir_t                dir;
    logic [WIDTH-1:0]    cnt_nxt;
    dir_t                dir_nxt;
    logic                boundary;
    logic [CHANNELS-1:0] pwm_raw;

    always_comb begin
        cfg_in        = '0;
        cfg_in.center = center_i;
        cfg_in.period = period_i;
        cfg_in.thr    = thres_i;
`ifdef PWM_POLARITY_EN
        cfg_in.pol    = polarity_i;
`endif
    end

    // Next counter value; a boundary is any enabled cycle that wraps the counter to 0.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cnt_nxt  = '0;
        dir_nxt  = DIR_UP;
        boundary = 1'b0;
        if (!enable_i) begin
            cnt_nxt = '0;
        end else if (!cfg_a.center) begin
            if (cnt >= cfg_a.period) boundary = 1'b1;
            else                     cnt_nxt  = cnt + 1'b1;
        end else if (dir == DIR_UP) begin
            if (cnt < cfg_a.period) begin
                cnt_nxt = cnt + 1'b1;
            end else if (cfg_a.period <= WIDTH'(1)) begin
                boundary = 1'b1;
            end else begin
                cnt_nxt = cfg_a.period - 1'b1;
                dir_nxt = DIR_DOWN;
            end
        end else begin
            if (cnt <= WIDTH'(1)) begin
                boundary = 1'b1;
            end else begin
                cnt_nxt = cnt - 1'b1;
                dir_nxt = DIR_DOWN;
            end
        end
    end

    always_comb begin
        pwm_raw = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            pwm_raw[k] = enable_i & (cnt < cfg_a.thr[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            dir       <= DIR_UP;
            // NOTE: the config is plain flops, not a RAM, so it is reset along with the rest.
            cfg_a     <= '0;
            cfg_p     <= '0;
            pending_o <= 1'b0;
            cycle_o   <= 1'b0;
            pwm_o     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            cnt     <= cnt_nxt;
            dir     <= dir_nxt;
            cycle_o <= boundary;
`ifdef PWM_POLARITY_EN
            pwm_o   <= cfg_a.pol ^ pwm_raw;
`else
            pwm_o   <= pwm_raw;
`endif
            if (!enable_i) begin
                // Idle: loads go straight to active, and any leftover shadow is flushed.
                if (load_i)         cfg_a <= cfg_in;
                else if (pending_o) cfg_a <= cfg_p;
                pending_o <= 1'b0;
            end else begin
                if (boundary && pending_o) cfg_a <= cfg_p;
                if (load_i) begin
                    cfg_p     <= cfg_in;
                    pending_o <= 1'b1;
                end else if (boundary) begin
                    pending_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Directed bench for pwm_multi_ctrl: edge/centre sequences, shadow loads, P=0 and async reset.
module tb_pwm_multi_ctrl;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;

    logic                      clk;
    logic                      rst;
    logic                      enable_i;
    logic                      center_i;
    logic [WIDTH-1:0]          period_i;
    logic [CHANNELS*WIDTH-1:0] thres_i;
    logic                      load_i;
    logic                      pending_o;
    logic                      cycle_o;
    logic [CHANNELS-1:0]       pwm_o;
`ifdef PWM_POLARITY_EN
    logic [CHANNELS-1:0]       polarity_i;
    initial polarity_i = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multi_ctrl #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable_i  (enable_i),
        .center_i  (center_i),
        .period_i  (period_i),
        .thres_i   (thres_i),
        .load_i    (load_i),
`ifdef PWM_POLARITY_EN
        .polarity_i(polarity_i),
`endif
        .pending_o (pending_o),
        .cycle_o   (cycle_o),
        .pwm_o     (pwm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic c, input logic [WIDTH-1:0] p,
                           input logic [WIDTH-1:0] t0, input logic [WIDTH-1:0] t1,
                           input logic [WIDTH-1:0] t2, input logic [WIDTH-1:0] t3);
        center_i = c;
        period_i = p;
        thres_i  = {t3, t2, t1, t0};
    endtask

    task automatic load_disabled(input logic c, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] t0,
                                 input logic [WIDTH-1:0] t1, input logic [WIDTH-1:0] t2);
        enable_i = 1'b0;
        set_cfg(c, p, t0, t1, t2, '0);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("load_dis_pending", 32'(pending_o), 32'd0);
        enable_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    int idx;
    logic p0;

    initial begin
        rst      = 1'b1;
        enable_i = 1'b0;
        load_i   = 1'b0;
        set_cfg(1'b0, '0, '0, '0, '0, '0);
        #2 rst = 1'b0;
        #1;
        check("rst_pwm", 32'(pwm_o), 32'd0);
        check("rst_cycle", 32'(cycle_o), 32'd0);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_cnt", 32'(dut.cnt), 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Edge mode P=4: thr0=2, thr1=0, thr2=5
        load_disabled(1'b0, 16'd4, 16'd2, 16'd0, 16'd5);
        for (int k = 1; k <= 15; k++) begin
            tick();
            p0 = ((k - 1) % 5) < 2;
            check("edge_pwm", 32'(pwm_o), 32'({3'b010, p0}));
            check("edge_cycle", 32'(cycle_o), 32'(((k - 1) % 5) == 4));
        end

        enable_i = 1'b0;
        tick();
        check("dis_pwm", 32'(pwm_o), 32'd0);
        check("dis_cycle", 32'(cycle_o), 32'd0);

        // Centre mode P=4, thr0=2
        load_disabled(1'b1, 16'd4, 16'd2, 16'd0, 16'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            idx = (k - 1) % 8;
            check("ctr_pwm", 32'(pwm_o), 32'(cseq[idx] < 2));
            check("ctr_cycle", 32'(cycle_o), 32'(idx == 7));
            check("ctr_cnt", 32'(dut.cnt), 32'(cseq[k % 8]));
        end

        // P=9 edge, reload P=3 while cnt=4
        load_disabled(1'b0, 16'd9, 16'd5, 16'd0, 16'd0);
        for (int k = 1; k <= 4; k++) tick();
        check("p9_cnt4", 32'(dut.cnt), 32'd4);
        set_cfg(1'b0, 16'd3, 16'd2, '0, '0, '0);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("p9_pend_set", 32'(pending_o), 32'd1);
        for (int k = 6; k <= 9; k++) begin
            tick();
            check("p9_pend_hold", 32'(pending_o), 32'd1);
        end
        check("p9_cnt9", 32'(dut.cnt), 32'd9);
        tick();
        check("p9_pend_clr", 32'(pending_o), 32'd0);
        check("p9_bnd_cycle", 32'(cycle_o), 32'd1);
        check("p9_bnd_cnt", 32'(dut.cnt), 32'd0);
        check("p9_bnd_pwm", 32'(pwm_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("p3_pwm", 32'(pwm_o), 32'(k < 2));
            check("p3_cycle", 32'(cycle_o), 32'(k == 3));
        end

        // Two loads in one period: thr0=3 then thr0=7
        set_cfg(1'b0, 16'd3, 16'd3, '0, '0, '0);
        load_i = 1'b1;
        tick();
        set_cfg(1'b0, 16'd3, 16'd7, '0, '0, '0);
        tick();
        load_i = 1'b0;
        check("two_pend", 32'(pending_o), 32'd1);
        tick();
        tick();
        check("two_applied_pend", 32'(pending_o), 32'd0);
        check("two_applied_cycle", 32'(cycle_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("two_pwm", 32'(pwm_o), 32'd1);
        end
        // Load on the boundary cycle (cnt=3): thr0=7 stays active, thr0=1 goes pending
        set_cfg(1'b0, 16'd3, 16'd1, '0, '0, '0);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("two_last_pwm_cnt3", 32'(pwm_o), 32'd1);
        check("bnd_load_pend", 32'(pending_o), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bnd_load_old_thr", 32'(pwm_o), 32'd1);
        end
        check("bnd_load_pend_clr", 32'(pending_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bnd_load_new_thr", 32'(pwm_o), 32'(k == 0));
        end

        // P=0, thr0=1: every enabled cycle is a boundary
        load_disabled(1'b0, 16'd0, 16'd1, 16'd0, 16'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("p0_cycle", 32'(cycle_o), 32'd1);
            check("p0_pwm", 32'(pwm_o), 32'd1);
            check("p0_cnt", 32'(dut.cnt), 32'd0);
        end
        // Enable falling while pending flushes the shadow into active
        set_cfg(1'b0, 16'd0, 16'd0, '0, '0, '0);
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
        check("fall_pend_set", 32'(pending_o), 32'd1);
        enable_i = 1'b0;
        tick();
        check("fall_pend_clr", 32'(pending_o), 32'd0);
        enable_i = 1'b1;
        tick();
        check("fall_thr0_applied", 32'(pwm_o), 32'd0);

        // Async reset mid-period at cnt=6
        load_disabled(1'b0, 16'd9, 16'd8, 16'd0, 16'd0);
        for (int k = 0; k < 6; k++) tick();
        check("pre_rst_cnt", 32'(dut.cnt), 32'd6);
        check("pre_rst_pwm", 32'(pwm_o), 32'd1);
        rst = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_o), 32'd0);
        check("async_rst_cycle", 32'(cycle_o), 32'd0);
        check("async_rst_pending", 32'(pending_o), 32'd0);
        check("async_rst_cnt", 32'(dut.cnt), 32'd0);
        #2 rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_pwm", 32'(pwm_o), 32'd0);
            check("post_rst_cnt", 32'(dut.cnt), 32'd0);
            check("post_rst_cycle", 32'(cycle_o), 32'd1);
            check("post_rst_pending", 32'(pending_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
